// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: MIPS opcode/funct/aluop types, control FSM states, select encodings, output bundle
package multicycle_control_pkg;
  localparam logic [4:0] RA_REG = 5'd31;
  localparam logic [31:0] PC_STEP = 32'd4;
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05,
    OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c,
    OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b, OP_HALT = 6'h3f
  } opcode_t;
  typedef enum logic [5:0] {
    F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22,
    F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2a,
    F_SLTU = 6'h2b
  } funct_t;
  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU, ALU_LUI
  } aluop_t;
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEMADDR, MEMREAD, MEMWRITE, WB_R, WB_I, WB_MEM, BRANCH, JUMP, JR, HALT
  } ctrl_state_t;
  localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3;
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
  localparam logic [1:0] M2R_ALU = 2'd0, M2R_MEM = 2'd1, M2R_PC = 2'd2;
  typedef struct packed {
    aluop_t aluop;
    logic alusrca;
    logic [1:0] alusrcb;
    logic extop;
    logic iren;
    logic dren;
    logic dwen;
    logic regwrite;
    logic pcw;
    logic [1:0] pcsrc;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic halt;
  } ctrl_out_t;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control <-> datapath/cache bundle
//   master (control): in instr/ihit/dhit/zero/overflow; out ALU selects, enables, mux selects, halt
//   slave (datapath): the reverse
interface multicycle_control_if;
  import multicycle_control_pkg::*;
  logic [31:0] instr;
  logic ihit, dhit, zero, overflow;
  aluop_t aluop;
  logic alusrca, extop, irwrite, pcwrite, iREN, dREN, dWEN, regwrite, halt;
  logic [1:0] alusrcb, pcsrc, regdst, memtoreg;
  modport master(
    input instr, ihit, dhit, zero, overflow,
    output aluop, alusrca, alusrcb, extop, irwrite, pcwrite, pcsrc, iREN, dREN, dWEN, regwrite, regdst, memtoreg, halt
  );
  modport slave(
    output instr, ihit, dhit, zero, overflow,
    input aluop, alusrca, alusrcb, extop, irwrite, pcwrite, pcsrc, iREN, dREN, dWEN, regwrite, regdst, memtoreg, halt
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// multicycle_control_alu_decoder: opcode/funct -> aluop, extop, trap_op (signed op that may trap on overflow)
module multicycle_control_alu_decoder import multicycle_control_pkg::*; (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output aluop_t     aluop,
  output logic       extop,
  output logic       trap_op
);
  always_comb begin
    aluop = ALU_ADD;
    extop = 1'b1;
    trap_op = 1'b0;
    case (opcode)
      OP_RTYPE: case (funct)
        F_SLL: aluop = ALU_SLL;
        F_SRL: aluop = ALU_SRL;
        F_ADD: trap_op = 1'b1;
        F_SUB: begin aluop = ALU_SUB; trap_op = 1'b1; end
        F_SUBU: aluop = ALU_SUB;
        F_AND: aluop = ALU_AND;
        F_OR: aluop = ALU_OR;
        F_XOR: aluop = ALU_XOR;
        F_NOR: aluop = ALU_NOR;
        F_SLT: aluop = ALU_SLT;
        F_SLTU: aluop = ALU_SLTU;
        default: ;
      endcase
      OP_ADDI: trap_op = 1'b1;
      OP_SLTI: aluop = ALU_SLT;
      OP_SLTIU: aluop = ALU_SLTU;
      OP_ANDI: begin aluop = ALU_AND; extop = 1'b0; end
      OP_ORI: begin aluop = ALU_OR; extop = 1'b0; end
      OP_XORI: begin aluop = ALU_XOR; extop = 1'b0; end
      OP_LUI: aluop = ALU_LUI;
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM (CLK, nRST async active-low, bus = master side of multicycle_control_if)
//   OVERFLOW_TRAP_EN: when defined, ADD/SUB/ADDI with overflow in EXEC go to HALT instead of writeback
module multicycle_control import multicycle_control_pkg::*; (
  input logic CLK,
  input logic nRST,
  multicycle_control_if.master bus
);
  ctrl_state_t state, nxt;
  ctrl_out_t q, n;
  aluop_t dec_aluop;
  logic [5:0] op, fn;
  logic dec_extop, dec_trap, trap, unused_bits;
  assign op = bus.instr[31:26];
  assign fn = bus.instr[5:0];
  assign unused_bits = ^{bus.instr[25:6], bus.overflow, dec_trap};
  multicycle_control_alu_decoder u_dec (.opcode(op), .funct(fn), .aluop(dec_aluop), .extop(dec_extop), .trap_op(dec_trap));
`ifdef OVERFLOW_TRAP_EN
  assign trap = dec_trap & bus.overflow;
`else
  assign trap = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      FETCH: if (bus.ihit && q.iren) nxt = DECODE;
      DECODE: case (op)
        OP_RTYPE: nxt = (fn == F_JR) ? JR : EXEC_R;
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: nxt = EXEC_I;
        OP_LW, OP_SW: nxt = MEMADDR;
        OP_BEQ, OP_BNE: nxt = BRANCH;
        OP_J, OP_JAL: nxt = JUMP;
        OP_HALT: nxt = HALT;
        default: nxt = FETCH;
      endcase
      EXEC_R: nxt = trap ? HALT : WB_R;
      EXEC_I: nxt = trap ? HALT : WB_I;
      MEMADDR: nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD: if (bus.dhit) nxt = WB_MEM;
      MEMWRITE: if (bus.dhit) nxt = FETCH;
      WB_R, WB_I, WB_MEM, BRANCH, JUMP, JR: nxt = FETCH;
      default: ;
    endcase
  end
  // Outputs are decoded from the upcoming state and registered, so they track state exactly
  // and are all zero while reset is held.
  always_comb begin
    n = '0;
    case (nxt)
      FETCH: begin n.iren = 1'b1; n.alusrcb = 2'd1; n.aluop = ALU_ADD; n.pcsrc = PC_ALU; end
      DECODE: begin n.alusrcb = 2'd3; n.extop = 1'b1; n.aluop = ALU_ADD; end
      EXEC_R: begin n.alusrca = 1'b1; n.aluop = dec_aluop; end
      EXEC_I: begin n.alusrca = 1'b1; n.alusrcb = 2'd2; n.extop = dec_extop; n.aluop = dec_aluop; end
      MEMADDR: begin n.alusrca = 1'b1; n.alusrcb = 2'd2; n.extop = 1'b1; n.aluop = ALU_ADD; end
      MEMREAD: n.dren = 1'b1;
      MEMWRITE: n.dwen = 1'b1;
      WB_R: begin n.regwrite = 1'b1; n.regdst = RD_RD; n.memtoreg = M2R_ALU; end
      WB_I: begin n.regwrite = 1'b1; n.regdst = RD_RT; end
      WB_MEM: begin n.regwrite = 1'b1; n.regdst = RD_RT; n.memtoreg = M2R_MEM; end
      BRANCH: begin n.alusrca = 1'b1; n.aluop = ALU_SUB; n.pcsrc = PC_ALUOUT; end
      JUMP: begin
        n.pcsrc = PC_JUMP;
        n.pcw = 1'b1;
        n.regwrite = (op == OP_JAL);
        n.regdst = (op == OP_JAL) ? RD_RA : RD_RT;
        n.memtoreg = (op == OP_JAL) ? M2R_PC : M2R_ALU;
      end
      JR: begin n.pcsrc = PC_RS; n.pcw = 1'b1; end
      HALT: n.halt = 1'b1;
      default: ;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= FETCH;
      q <= '0;
    end else begin
      state <= nxt;
      q <= n;
    end
  // FETCH waits for the registered iREN so a hit in the first cycle out of reset is not consumed.
  assign bus.irwrite = (state == FETCH) & q.iren & bus.ihit;
  assign bus.pcwrite = bus.irwrite | q.pcw | ((state == BRANCH) & (bus.zero ^ (op == OP_BNE)));
  assign bus.aluop = q.aluop;
  assign bus.alusrca = q.alusrca;
  assign bus.alusrcb = q.alusrcb;
  assign bus.extop = q.extop;
  assign bus.pcsrc = q.pcsrc;
  assign bus.iREN = q.iren;
  assign bus.dREN = q.dren;
  assign bus.dWEN = q.dwen;
  assign bus.regwrite = q.regwrite;
  assign bus.regdst = q.regdst;
  assign bus.memtoreg = q.memtoreg;
  assign bus.halt = q.halt;
endmodule
